rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//   Boot-time program loader that sits directly downstream of the generated program ROM.
//   - Walks the ROM byte address from 0 and samples the combinational rom_byte output.
//   - Packs bytes little-endian into 32-bit words and writes them into main memory over a
//     valid/ready write port.
//   - Holds the CPU in reset until the last byte (ROM done flag) has been committed.
// PARAMETERS
//   BASE_ADDR  32'h0   memory byte address that ROM byte 0 is loaded to (must be 4-aligned)
//   MAX_BYTES  65536   guard limit; load stops with overflow if ROM done never asserts
// PORTS
//   clk          in   1   system clock; all logic on rising edge
//   reset        in   1   synchronous, active-high reset
//   start        in   1   begin load; sampled only in IDLE
//   rom_address  out  32  byte address to ROM (registered)
//   rom_byte     in   8   ROM data for rom_address, valid in the same cycle (combinational ROM)
//   rom_done     in   1   high when rom_address is the last ROM byte
//   mem_addr     out  32  word-aligned write address = BASE_ADDR + {rom_address[31:2],2'b00}
//   mem_data     out  32  packed word; byte lane i = ROM byte at word offset i
//   mem_be       out  4   byte enables; bit i set iff lane i was filled from ROM
//   mem_write    out  1   write request (valid)
//   mem_ready    in   1   memory accepts write when mem_write && mem_ready at clock edge
//   busy         out  1   high in FETCH or WRITE
//   load_done    out  1   high in DONE
//   overflow     out  1   sticky; MAX_BYTES reached without rom_done
//   cpu_reset    out  1   high from reset until DONE entered, low only in DONE
//   byte_count   out  32  number of ROM bytes captured so far
// BEHAVIOUR
//   Reset values: state=IDLE; rom_address=0; mem_data=0; mem_be=0; mem_write=0; busy=0;
//     load_done=0; overflow=0; cpu_reset=1; byte_count=0; mem_addr=BASE_ADDR.
//   Reset mid-load aborts immediately to the reset values; no partial word is written.
//   IDLE:  start=1 -> FETCH with rom_address=0, mem_be=0, mem_data=0. start=0 -> stay.
//   FETCH (one byte per cycle):
//     - At the edge, latch rom_byte into lane rom_address[1:0], set that mem_be bit,
//       and increment byte_count.
//     - last = rom_done || (byte_count+1 == MAX_BYTES). last without rom_done also sets overflow.
//     - If lane==3 or last -> WRITE (rom_address held); else rom_address+1, stay in FETCH.
//     - mem_ready is ignored in FETCH.
//   WRITE:
//     - mem_write=1; mem_addr, mem_data and mem_be are stable until the handshake.
//     - On mem_write && mem_ready: clear mem_write.
//       - If the captured word was last -> DONE.
//       - Otherwise rom_address+1, mem_be=0, mem_data=0 -> FETCH.
//     - mem_ready low: hold indefinitely.
//   DONE: load_done=1, cpu_reset=0, rom_address held; start ignored; exit only via reset.
//   start asserted while busy or in DONE: ignored.
//   Partial final word: unused lanes are 0 and their mem_be bits are 0.
//   Timing with mem_ready tied high: each full word = 4 FETCH + 1 WRITE cycle.
//     For a ROM of L bytes (L multiple of 4), load_done rises 5*L/4 edges after the edge
//     that samples start.
//   rom_address never advances past the byte at which rom_done was seen.
// TESTING
//   1. Real 432-byte ROM (done@431), mem_ready=1, pulse start:
//      -> 108 writes, mem_addr 0..428 step 4, all mem_be=4'b1111;
//         word@8 = 32'h09_00_14_0E (bytes 8..11 = 14,20,0,9);
//         load_done and cpu_reset=0 exactly 540 edges after start.
//   2. Stub ROM done@5, bytes 1..6:
//      -> word@0 = 32'h04030201, be=1111;
//         word@4 = 32'h00000605, be=0011;
//         byte_count=6; load_done.
//   3. mem_ready low 3 cycles on 2nd write
//      -> mem_write, mem_addr=4, mem_data held stable; rom_address frozen;
//         handshake on 4th cycle; total load 3 cycles longer.
//   4. Reset asserted during FETCH of word 10, then start again
//      -> outputs at reset values the next cycle; reload begins at rom_address 0,
//         first write at mem_addr=BASE_ADDR.
//   5. MAX_BYTES=8, rom_done never high
//      -> 2 full writes, overflow=1, load_done=1, byte_count=8.
//   6. start held high throughout and re-pulsed in DONE
//      -> exactly one load; no writes after DONE; BASE_ADDR=32'h100 puts byte 0 at 32'h100.

Source files
------------

// File: rtl/rom_loader.sv
// Boot loader: walks a combinational program ROM, packs bytes little-endian into words
// and writes them to memory over a valid/ready port, holding the CPU in reset until done.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_be,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        busy,
  output logic        load_done,
  output logic        overflow,
  output logic        cpu_reset,
  output logic [31:0] byte_count
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam int unsigned LANES = 4;

  state_t      state_q, state_d;
  logic [31:0] rom_address_q, rom_address_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        mem_write_q, mem_write_d;
  logic        busy_q, busy_d;
  logic        load_done_q, load_done_d;
  logic        overflow_q, overflow_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic [31:0] byte_count_q, byte_count_d;
  logic        last_q, last_d;
  logic        is_last;
  logic [1:0]  lane;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rom_address_q <= '0;
      mem_addr_q    <= BASE_ADDR;
      mem_data_q    <= '0;
      mem_be_q      <= '0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      overflow_q    <= 1'b0;
      cpu_reset_q   <= 1'b1;
      byte_count_q  <= '0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_address_q <= rom_address_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_be_q      <= mem_be_d;
      mem_write_q   <= mem_write_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
      overflow_q    <= overflow_d;
      cpu_reset_q   <= cpu_reset_d;
      byte_count_q  <= byte_count_d;
      last_q        <= last_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    rom_address_d = rom_address_q;
    mem_data_d    = mem_data_q;
    mem_be_d      = mem_be_q;
    mem_write_d   = mem_write_q;
    overflow_d    = overflow_q;
    byte_count_d  = byte_count_q;
    last_d        = last_q;
    lane          = rom_address_q[1:0];
    is_last       = rom_done || ((byte_count_q + 32'd1) == 32'(MAX_BYTES));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = FETCH;
          rom_address_d = '0;
          mem_data_d    = '0;
          mem_be_d      = '0;
          byte_count_d  = '0;
          last_d        = 1'b0;
        end
      end
      FETCH: begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (lane == 2'(i)) begin
            mem_data_d[8*i +: 8] = rom_byte;
            mem_be_d[i]          = 1'b1;
          end
        end
        byte_count_d = byte_count_q + 32'd1;
        if (is_last && !rom_done) overflow_d = 1'b1;
        if (lane == 2'd3 || is_last) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          last_d      = is_last;
        end else begin
          rom_address_d = rom_address_q + 32'd1;
        end
      end
      WRITE: begin
        if (mem_write_q && mem_ready) begin
          mem_write_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            state_d       = FETCH;
            rom_address_d = rom_address_q + 32'd1;
            mem_data_d    = '0;
            mem_be_d      = '0;
          end
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // Status outputs registered from the next state so they align with it
    busy_d      = (state_d == FETCH) || (state_d == WRITE);
    load_done_d = (state_d == DONE);
    cpu_reset_d = (state_d != DONE);
    mem_addr_d  = BASE_ADDR + {rom_address_d[31:2], 2'b00};
  end

  assign rom_address = rom_address_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_be      = mem_be_q;
  assign mem_write   = mem_write_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign overflow    = overflow_q;
  assign cpu_reset   = cpu_reset_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: default instance plus a BASE_ADDR=0x100,
// MAX_BYTES=8 instance for the overflow and base-offset cases.
module tb_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance 0: BASE_ADDR=0, MAX_BYTES default
  logic        reset0, start0, rdy0;
  logic [31:0] rom_address0, mem_addr0, mem_data0, byte_count0;
  logic [7:0]  rom_byte0;
  logic        rom_done0;
  logic [3:0]  mem_be0;
  logic        mem_write0, busy0, load_done0, overflow0, cpu_reset0;
  logic [7:0]  rom0 [512];
  logic [31:0] done_idx0;

  assign rom_byte0 = (rom_address0 < 32'd512) ? rom0[rom_address0[8:0]] : 8'h00;
  assign rom_done0 = (rom_address0 == done_idx0);

  rom_loader u_dut0 (
    .clk(clk), .reset(reset0), .start(start0),
    .rom_address(rom_address0), .rom_byte(rom_byte0), .rom_done(rom_done0),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .mem_be(mem_be0),
    .mem_write(mem_write0), .mem_ready(rdy0),
    .busy(busy0), .load_done(load_done0), .overflow(overflow0),
    .cpu_reset(cpu_reset0), .byte_count(byte_count0)
  );

  // Instance 1: BASE_ADDR=0x100, MAX_BYTES=8, ROM never signals done
  logic        reset1, start1, rdy1;
  logic [31:0] rom_address1, mem_addr1, mem_data1, byte_count1;
  logic [7:0]  rom_byte1;
  logic        rom_done1;
  logic [3:0]  mem_be1;
  logic        mem_write1, busy1, load_done1, overflow1, cpu_reset1;

  assign rom_byte1 = 8'hA0 + rom_address1[7:0];
  assign rom_done1 = 1'b0;

  rom_loader #(.BASE_ADDR(32'h100), .MAX_BYTES(8)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1),
    .rom_address(rom_address1), .rom_byte(rom_byte1), .rom_done(rom_done1),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_be(mem_be1),
    .mem_write(mem_write1), .mem_ready(rdy1),
    .busy(busy1), .load_done(load_done1), .overflow(overflow1),
    .cpu_reset(cpu_reset1), .byte_count(byte_count1)
  );

  // Write monitors, sampled mid-cycle; a handshake completes on the following rising edge
  int          wc0 = 0, wc1 = 0;
  logic [31:0] wa0 [128], wd0 [128], wa1 [8], wd1 [8];
  logic [3:0]  wb0 [128], wb1 [8];

  always @(negedge clk) begin
    if (reset0) wc0 <= 0;
    else if (mem_write0 && rdy0 && wc0 < 128) begin
      wa0[wc0] <= mem_addr0; wd0[wc0] <= mem_data0; wb0[wc0] <= mem_be0;
      wc0 <= wc0 + 1;
    end
  end

  always @(negedge clk) begin
    if (reset1) wc1 <= 0;
    else if (mem_write1 && rdy1 && wc1 < 8) begin
      wa1[wc1] <= mem_addr1; wd1[wc1] <= mem_data1; wb1[wc1] <= mem_be1;
      wc1 <= wc1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst0();
    reset0 = 1'b1;
    step();
    reset0 = 1'b0;
    step();
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until load_done is seen
  task automatic wait_done(input int which, output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      n++;
      #1;
      if ((which == 0 && load_done0) || (which == 1 && load_done1)) break;
    end
    chk("wait_done_timeout", (which == 0) ? 32'(load_done0) : 32'(load_done1), 32'd1);
  endtask

  task automatic load_real();
    for (int i = 0; i < 512; i++) rom0[i] = 8'((i * 37) + 5);
    rom0[8] = 8'd14; rom0[9] = 8'd20; rom0[10] = 8'd0; rom0[11] = 8'd9;
    done_idx0 = 32'd431;
  endtask

  task automatic load_stub();
    for (int i = 0; i < 512; i++) rom0[i] = 8'h00;
    for (int i = 0; i < 6; i++) rom0[i] = 8'(i + 1);
    done_idx0 = 32'd5;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_rom_address"}, rom_address0, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr0, 32'h0);
    chk({tag, "_mem_data"}, mem_data0, 32'h0);
    chk({tag, "_mem_be"}, 32'(mem_be0), 32'h0);
    chk({tag, "_mem_write"}, 32'(mem_write0), 32'h0);
    chk({tag, "_busy"}, 32'(busy0), 32'h0);
    chk({tag, "_load_done"}, 32'(load_done0), 32'h0);
    chk({tag, "_overflow"}, 32'(overflow0), 32'h0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset0), 32'h1);
    chk({tag, "_byte_count"}, byte_count0, 32'h0);
  endtask

  initial begin
    int n;
    int bad;
    reset0 = 1'b1; reset1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    done_idx0 = 32'd0;
    load_real();
    step(); step();
    chk_reset0("rst");
    chk("rst1_mem_addr", mem_addr1, 32'h100);
    chk("rst1_cpu_reset", 32'(cpu_reset1), 32'h1);
    reset0 = 1'b0; reset1 = 1'b0;
    step();

    // 432-byte ROM, ready tied high
    pulse0();
    chk("t1_busy_after_start", 32'(busy0), 32'h1);
    wait_done(0, n);
    chk("t1_latency", 32'(n), 32'd540);
    chk("t1_cpu_reset", 32'(cpu_reset0), 32'h0);
    chk("t1_writes", 32'(wc0), 32'd108);
    bad = 0;
    for (int i = 0; i < 108; i++)
      if (wa0[i] !== 32'(4 * i) || wb0[i] !== 4'b1111) bad++;
    chk("t1_addr_be_seq", 32'(bad), 32'd0);
    chk("t1_word8", wd0[2], 32'h0900140E);
    chk("t1_byte_count", byte_count0, 32'd432);
    chk("t1_rom_address", rom_address0, 32'd431);
    chk("t1_overflow", 32'(overflow0), 32'h0);
    chk("t1_busy_done", 32'(busy0), 32'h0);

    // Stub ROM of 6 bytes, partial final word
    rst0();
    chk_reset0("t2rst");
    load_stub();
    pulse0();
    wait_done(0, n);
    chk("t2_latency", 32'(n), 32'd8);
    chk("t2_writes", 32'(wc0), 32'd2);
    chk("t2_w0_addr", wa0[0], 32'h0);
    chk("t2_w0_data", wd0[0], 32'h04030201);
    chk("t2_w0_be", 32'(wb0[0]), 32'hF);
    chk("t2_w1_addr", wa0[1], 32'h4);
    chk("t2_w1_data", wd0[1], 32'h00000605);
    chk("t2_w1_be", 32'(wb0[1]), 32'h3);
    chk("t2_byte_count", byte_count0, 32'd6);

    // Back-pressure: ready low for 3 cycles on the second write
    rst0();
    load_stub();
    pulse0();
    repeat (7) step();
    rdy0 = 1'b0;
    chk("t3_mem_write", 32'(mem_write0), 32'h1);
    chk("t3_mem_addr", mem_addr0, 32'h4);
    chk("t3_mem_data", mem_data0, 32'h00000605);
    chk("t3_rom_address", rom_address0, 32'd5);
    bad = 0;
    repeat (3) begin
      step();
      if (mem_write0 !== 1'b1 || mem_addr0 !== 32'h4 || mem_data0 !== 32'h00000605 ||
          mem_be0 !== 4'b0011 || rom_address0 !== 32'd5)
        bad++;
    end
    chk("t3_hold_stable", 32'(bad), 32'd0);
    chk("t3_not_done_yet", 32'(load_done0), 32'h0);
    rdy0 = 1'b1;
    step();
    chk("t3_done_after_11", 32'(load_done0), 32'h1);
    chk("t3_writes", 32'(wc0), 32'd2);

    // Reset while fetching word 10, then reload
    rst0();
    load_real();
    pulse0();
    for (int k = 0; k < 200; k++) begin
      if (rom_address0 == 32'd41 && busy0 && !mem_write0) break;
      step();
    end
    chk("t4_reached_word10", rom_address0, 32'd41);
    chk("t4_writes_before", 32'(wc0), 32'd10);
    reset0 = 1'b1;
    step();
    chk_reset0("t4abort");
    reset0 = 1'b0;
    step();
    pulse0();
    chk("t4_restart_addr", rom_address0, 32'h0);
    wait_done(0, n);
    chk("t4_latency", 32'(n), 32'd540);
    chk("t4_first_addr", wa0[0], 32'h0);
    chk("t4_writes", 32'(wc0), 32'd108);

    // MAX_BYTES=8 guard with BASE_ADDR=0x100
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    wait_done(1, n);
    chk("t5_latency", 32'(n), 32'd10);
    chk("t5_writes", 32'(wc1), 32'd2);
    chk("t5_w0_addr", wa1[0], 32'h100);
    chk("t5_w0_data", wd1[0], 32'hA3A2A1A0);
    chk("t5_w1_addr", wa1[1], 32'h104);
    chk("t5_w1_data", wd1[1], 32'hA7A6A5A4);
    chk("t5_be", {24'h0, wb1[0], wb1[1]}, 32'hFF);
    chk("t5_overflow", 32'(overflow1), 32'h1);
    chk("t5_byte_count", byte_count1, 32'd8);
    chk("t5_cpu_reset", 32'(cpu_reset1), 32'h0);

    // start held high, then re-pulsed in DONE
    rst0();
    load_stub();
    start0 = 1'b1;
    wait_done(0, n);
    chk("t6_latency", 32'(n), 32'd9);
    repeat (5) step();
    start0 = 1'b0;
    step();
    pulse0();
    repeat (5) step();
    chk("t6_writes", 32'(wc0), 32'd2);
    chk("t6_load_done", 32'(load_done0), 32'h1);
    chk("t6_mem_write", 32'(mem_write0), 32'h0);
    chk("t6_busy", 32'(busy0), 32'h0);
    chk("t6_rom_address", rom_address0, 32'd5);
    chk("t6_byte_count", byte_count0, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
